bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter/controller for the shared broadcast bus. It owns the single
//  bus and serves DRVRS driver FIFOs: it picks one pending driver, pops its head word,
//  decodes the destination ID and pushes the word to the destination (or to all
//  others on broadcast). Sits between the driver-side FIFOs and receiver-side FIFOs.
// PARAMETERS
//  BITS   16  packet width; dest ID = D_pop[BITS-1 -: ID_W]
//  DRVRS  4   number of drivers/receivers (>=2)
//  ID_W   8   destination-ID field width; all-ones = broadcast (BCAST)
// PORTS
//  clk       in   1           bus clock, all logic on rising edge
//  reset     in   1           asynchronous, active-low reset
//  pndng     in   DRVRS       bit d = driver d FIFO non-empty
//  D_pop     in   DRVRS*BITS  slice d = head word of driver d FIFO
//  pop       out  DRVRS       one-hot pop strobe to granted driver FIFO
//  push      out  DRVRS       push strobes to receiver FIFOs
//  D_push    out  BITS        bus data, valid while any push bit high
//  grant_id  out  $clog2(DRVRS) index of current/last granted driver
//  bus_busy  out  1           high in GRANT and DELIVER
//  drop      out  1           one-cycle pulse: packet discarded (bad dest)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; pop, push, D_push, grant_id, bus_busy, drop = 0;
//   rr pointer = DRVRS-1 so driver 0 wins first. In-flight word is lost.
//  FSM IDLE -> GRANT -> DELIVER -> {GRANT | IDLE}:
//   IDLE: if |pndng: winner = first set bit searching ptr+1, ptr+2.. mod DRVRS;
//     register grant_id=winner, ptr=winner; -> GRANT. Else stay.
//   GRANT: pop[grant_id]=1 for exactly this cycle; D_push <= D_pop[grant_id]; -> DELIVER.
//   DELIVER: decode dest=D_push[BITS-1 -: ID_W]:
//     dest==BCAST           -> push = all ones except bit grant_id
//     dest<DRVRS, !=grant_id -> push = one-hot(dest)
//     else (out of range or self) -> push=0, drop=1
//     push/drop are high only this cycle. Then if |pndng re-arbitrate as in IDLE
//     (pndng now reflects the pop) and -> GRANT; else -> IDLE.
//  Latency: pndng seen in IDLE at cycle n -> pop at n+1 -> push at n+2.
//   Saturated bus: one transfer every 2 cycles.
//  Fairness: a driver that keeps pndng high waits at most DRVRS-1 other transfers.
//  pndng dropping between arbitration and GRANT: pop still issued; data treated as
//   valid (FIFO contract forbids this; not checked).
//  pop and push are never high in the same cycle; push never includes grant_id.
//  D_push holds its last value outside DELIVER; grant_id holds until next arbitration.
// CONFIGURATION
//  BUS_ARB_STATS_EN defined: adds outputs xfer_cnt[15:0] (+1 per DELIVER with push!=0)
//   and drop_cnt[15:0] (+1 per drop pulse); both saturate at 16'hFFFF, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: hold reset=0 with random inputs -> all outputs 0, state IDLE; release, pndng=0 -> stays idle.
//  2 Single: pndng=4'b0010, D_pop[1]=16'h02AB -> pop=4'b0010 at n+1, push=4'b0100, D_push=16'h02AB at n+2, grant_id=1.
//  3 Fairness: pndng=4'b1111 held, valid dests -> grant_id sequence 0,1,2,3,0; pop every 2nd cycle.
//  4 Broadcast: driver 2 sends 16'hFF5A alone -> push=4'b1011, D_push=16'hFF5A, drop=0.
//  5 Bad dest: driver 0 sends 16'h0711, then 16'h0011 -> push=0, drop=1 both times; with BUS_ARB_STATS_EN drop_cnt=2, xfer_cnt=0.
//  6 Reset mid-op: assert reset=0 during DELIVER -> push=0 same cycle, IDLE after release, next grant to driver 0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin owner of the shared broadcast bus.
// Picks one pending driver FIFO, pops its head word, then pushes that word to
// the destination receiver FIFO (or to every other receiver on broadcast).
// Optional statistics counters are compiled in with BUS_ARB_STATS_EN.
module bus_rr_arbiter #(
    parameter  int BITS  = 16,
    parameter  int DRVRS = 4,
    parameter  int ID_W  = 8,
    localparam int IDX_W = $clog2(DRVRS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DRVRS-1:0]       pndng,
    input  logic [DRVRS*BITS-1:0]  D_pop,
    output logic [DRVRS-1:0]       pop,
    output logic [DRVRS-1:0]       push,
    output logic [BITS-1:0]        D_push,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   bus_busy,
    output logic                   drop
`ifdef BUS_ARB_STATS_EN
    ,
    output logic [15:0]            xfer_cnt,
    output logic [15:0]            drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    localparam logic [IDX_W:0]     DRVRS_EXT = (IDX_W+1)'(DRVRS);
    localparam logic [ID_W-1:0]    BCAST     = {ID_W{1'b1}};
    localparam logic [ID_W-1:0]    DRVRS_ID  = ID_W'(DRVRS);
    localparam logic [DRVRS-1:0]   ONE_HOT0  = {{(DRVRS-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_nextState;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grantId;
    logic [BITS-1:0]    r_dPush;

    logic               w_anyPending;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W:0]     w_cand;
    logic [BITS-1:0]    w_popWords [DRVRS];
    logic [ID_W-1:0]    w_dest;
    logic [DRVRS-1:0]   w_grantOneHot;
    logic [DRVRS-1:0]   w_deliverPush;
    logic               w_deliverDrop;

    assign w_anyPending  = |pndng;
    assign w_grantOneHot = ONE_HOT0 << r_grantId;
    assign w_dest        = r_dPush[BITS-1 -: ID_W];

    // Split the flat head-word bus into one word per driver.
    always_comb begin
        for (int d = 0; d < DRVRS; d++) begin
            w_popWords[d] = D_pop[d*BITS +: BITS];
        end
    end

    // Round-robin search: first pending driver after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = '0;
        for (int i = 1; i <= DRVRS; i++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_cand >= DRVRS_EXT) begin
                w_cand = w_cand - DRVRS_EXT;
            end
            if (!w_found && pndng[w_cand[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDX_W-1:0];
            end
        end
    end

    // Destination decode of the latched word: broadcast, unicast or discard.
    always_comb begin
        w_deliverPush = '0;
        w_deliverDrop = 1'b0;
        if (w_dest == BCAST) begin
            w_deliverPush = ~w_grantOneHot;
        end else if ((w_dest < DRVRS_ID) && (w_dest != ID_W'(r_grantId))) begin
            w_deliverPush = ONE_HOT0 << w_dest;
        end else begin
            w_deliverDrop = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state: a transfer always takes GRANT then DELIVER.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyPending) w_nextState = GRANT;
            GRANT:   w_nextState = DELIVER;
            DELIVER: w_nextState = w_anyPending ? GRANT : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Arbitration result, pointer and captured bus word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr     <= IDX_W'(DRVRS-1);
            r_grantId <= '0;
            r_dPush   <= '0;
        end else begin
            if (((r_state == IDLE) || (r_state == DELIVER)) && w_anyPending) begin
                r_grantId <= w_winner;
                r_ptr     <= w_winner;
            end
            if (r_state == GRANT) begin
                r_dPush <= w_popWords[r_grantId];
            end
        end
    end

    // Strobes are decoded from state so an async reset clears them at once.
    always_comb begin
        pop      = (r_state == GRANT)   ? w_grantOneHot : '0;
        push     = (r_state == DELIVER) ? w_deliverPush : '0;
        drop     = (r_state == DELIVER) ? w_deliverDrop : 1'b0;
        bus_busy = (r_state != IDLE);
        D_push   = r_dPush;
        grant_id = r_grantId;
    end

`ifdef BUS_ARB_STATS_EN
    // Saturating transfer and discard counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if ((r_state == DELIVER) && (w_deliverPush != '0) && (xfer_cnt != 16'hFFFF)) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
            if ((r_state == DELIVER) && w_deliverDrop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: bench for bus_rr_arbiter with a driver FIFO model and
// a scoreboard of expected bus transfers. Counter checks need BUS_ARB_STATS_EN.
module tb_bus_rr_arbiter;

   typedef struct packed {
      logic [3:0]  ePush;
      logic [15:0] eData;
      logic        eDrop;
      logic [1:0]  eGid;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  pndng = '0;
   logic [63:0] D_pop = '0;
   logic [3:0]  pop;
   logic [3:0]  push;
   logic [15:0] D_push;
   logic [1:0]  grant_id;
   logic        bus_busy;
   logic        drop;
`ifdef BUS_ARB_STATS_EN
   logic [15:0] xfer_cnt;
   logic [15:0] drop_cnt;
`endif

   int compared = 0;
   int mismatched = 0;
   int cycleCount = 0;

   logic [15:0] fifoMem [4][8];
   int          fifoHead [4];
   int          fifoCount [4];

   exp_t        sb[$];
   logic [1:0]  grantQ[$];

   logic [3:0]  obsPop = '0;
   logic [3:0]  obsPush = '0;
   logic [15:0] obsData = '0;
   logic [1:0]  obsGid = '0;
   logic        obsDrop = 1'b0;
   logic        obsBusy = 1'b0;

   bus_rr_arbiter #(.BITS(16), .DRVRS(4), .ID_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .pndng(pndng),
      .D_pop(D_pop),
      .pop(pop),
      .push(push),
      .D_push(D_push),
      .grant_id(grant_id),
      .bus_busy(bus_busy),
      .drop(drop)
`ifdef BUS_ARB_STATS_EN
      ,
      .xfer_cnt(xfer_cnt),
      .drop_cnt(drop_cnt)
`endif
   );

   // Free-running bus clock.
   always #5 clk = ~clk;

   // Hard stop in case something waits forever.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic exp_t modelXfer(input int src, input logic [15:0] w);
      exp_t e;
      logic [7:0] dest;
      dest    = w[15:8];
      e.ePush = 4'b0000;
      e.eDrop = 1'b0;
      e.eData = w;
      e.eGid  = 2'(src);
      if (dest == 8'hFF) begin
         e.ePush = 4'b1111 & ~(4'b0001 << src);
      end else if ((dest < 8'd4) && (int'(dest) != src)) begin
         e.ePush = 4'b0001 << dest;
      end else begin
         e.eDrop = 1'b1;
      end
      return e;
   endfunction

   task automatic addExpected(input int src, input logic [15:0] w);
      sb.push_back(modelXfer(src, w));
   endtask

   task automatic loadWord(input int d, input logic [15:0] w);
      fifoMem[d][(fifoHead[d] + fifoCount[d]) % 8] = w;
      fifoCount[d] = fifoCount[d] + 1;
   endtask

   task automatic applyStimulus();
      for (int d = 0; d < 4; d++) begin
         pndng[d] = (fifoCount[d] > 0);
         D_pop[d*16 +: 16] = (fifoCount[d] > 0) ? fifoMem[d][fifoHead[d]] : 16'hDEAD;
      end
   endtask

   // One bus cycle: the FIFO model pops at the edge ending GRANT, new
   // inputs go out just after the edge, outputs are sampled on the falling edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         if (obsPop[d] && (fifoCount[d] > 0)) begin
            fifoHead[d]  = (fifoHead[d] + 1) % 8;
            fifoCount[d] = fifoCount[d] - 1;
         end
      end
      applyStimulus();
      @(negedge clk);
      obsPop  = pop;
      obsPush = push;
      obsData = D_push;
      obsGid  = grant_id;
      obsDrop = drop;
      obsBusy = bus_busy;
      cycleCount++;
   endtask

   task automatic test_reset();
      #1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pndng = 4'($urandom);
         D_pop = {$urandom, $urandom};
         @(negedge clk);
         compared++;
         if ({pop, push, D_push, grant_id, bus_busy, drop} !== 30'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: pop=%b push=%b D_push=%h gid=%0d busy=%b drop=%b, required all zero",
                     pop, push, D_push, grant_id, bus_busy, drop);
         end
      end
      for (int d = 0; d < 4; d++) begin
         fifoHead[d]  = 0;
         fifoCount[d] = 0;
      end
      applyStimulus();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         stepCycle();
         compared++;
         if ({obsBusy, obsPop, obsPush} !== 9'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: busy=%b pop=%b push=%b, required busy=0 pop=0 push=0",
                     obsBusy, obsPop, obsPush);
         end
      end
   endtask

   task automatic test_fairness();
      exp_t e;
      int   lastPop;
      lastPop = -1;
      loadWord(0, 16'h0100);
      loadWord(0, 16'h0355);
      loadWord(1, 16'h0200);
      loadWord(2, 16'h0300);
      loadWord(3, 16'h0000);
      addExpected(0, 16'h0100);
      addExpected(1, 16'h0200);
      addExpected(2, 16'h0300);
      addExpected(3, 16'h0000);
      addExpected(0, 16'h0355);
      grantQ = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      applyStimulus();
      for (int c = 0; (c < 30) && ((sb.size() > 0) || (grantQ.size() > 0)); c++) begin
         stepCycle();
         if ((obsPop != 4'b0) && (obsPush != 4'b0)) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL fair_overlap: pop=%b push=%b, required not both active", obsPop, obsPush);
         end
         if (obsPop != 4'b0) begin
            compared++;
            if (grantQ.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL fair_extra_pop: pop=%b, required no pop", obsPop);
            end else if ((obsPop !== (4'b0001 << grantQ[0])) || (obsGid !== grantQ[0])) begin
               mismatched++;
               $display("[TB] FAIL fair_grant: pop=%b gid=%0d, required gid=%0d", obsPop, obsGid, grantQ[0]);
            end
            if (grantQ.size() > 0) void'(grantQ.pop_front());
            if (lastPop >= 0) begin
               compared++;
               if (cycleCount - lastPop != 2) begin
                  mismatched++;
                  $display("[TB] FAIL fair_spacing: pop gap=%0d cycles, required 2", cycleCount - lastPop);
               end
            end
            lastPop = cycleCount;
         end
         if ((obsPush != 4'b0) || obsDrop) begin
            compared++;
            if (sb.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL fair_unexpected: push=%b drop=%b, required nothing", obsPush, obsDrop);
            end else begin
               e = sb.pop_front();
               if ((obsPush !== e.ePush) || (obsData !== e.eData) || (obsDrop !== e.eDrop) || (obsGid !== e.eGid)) begin
                  mismatched++;
                  $display("[TB] FAIL fair_xfer: push=%b data=%h drop=%b gid=%0d, required push=%b data=%h drop=%b gid=%0d",
                           obsPush, obsData, obsDrop, obsGid, e.ePush, e.eData, e.eDrop, e.eGid);
               end
            end
         end
      end
      compared++;
      if ((sb.size() != 0) || (grantQ.size() != 0)) begin
         mismatched++;
         $display("[TB] FAIL fair_timeout: %0d transfers and %0d grants outstanding, required 0", sb.size(), grantQ.size());
         sb.delete();
         grantQ.delete();
      end
      stepCycle();
      stepCycle();
   endtask

   task automatic test_single();
      exp_t e;
      loadWord(1, 16'h02AB);
      addExpected(1, 16'h02AB);
      applyStimulus();
      stepCycle();
      compared++;
      if ((obsPop !== 4'b0010) || (obsGid !== 2'd1) || (obsPush !== 4'b0000)) begin
         mismatched++;
         $display("[TB] FAIL single_pop: pop=%b gid=%0d push=%b, required pop=0010 gid=1 push=0000", obsPop, obsGid, obsPush);
      end
      stepCycle();
      e = sb.pop_front();
      compared++;
      if ((obsPush !== e.ePush) || (obsData !== e.eData) || (obsDrop !== e.eDrop) || (obsGid !== e.eGid) || (obsPop !== 4'b0)) begin
         mismatched++;
         $display("[TB] FAIL single_push: push=%b data=%h drop=%b gid=%0d pop=%b, required push=%b data=%h drop=%b gid=%0d pop=0000",
                  obsPush, obsData, obsDrop, obsGid, obsPop, e.ePush, e.eData, e.eDrop, e.eGid);
      end
      stepCycle();
      compared++;
      if ((obsBusy !== 1'b0) || (obsData !== 16'h02AB) || (obsGid !== 2'd1)) begin
         mismatched++;
         $display("[TB] FAIL single_hold: busy=%b data=%h gid=%0d, required busy=0 data=02ab gid=1", obsBusy, obsData, obsGid);
      end
   endtask

   task automatic test_broadcast();
      exp_t e;
      loadWord(2, 16'hFF5A);
      addExpected(2, 16'hFF5A);
      applyStimulus();
      stepCycle();
      compared++;
      if (obsPop !== 4'b0100) begin
         mismatched++;
         $display("[TB] FAIL bcast_pop: pop=%b, required 0100", obsPop);
      end
      stepCycle();
      e = sb.pop_front();
      compared++;
      if ((obsPush !== e.ePush) || (obsData !== e.eData) || (obsDrop !== e.eDrop) || (obsGid !== e.eGid)) begin
         mismatched++;
         $display("[TB] FAIL bcast_push: push=%b data=%h drop=%b gid=%0d, required push=%b data=%h drop=%b gid=%0d",
                  obsPush, obsData, obsDrop, obsGid, e.ePush, e.eData, e.eDrop, e.eGid);
      end
      stepCycle();
   endtask

   task automatic test_bad_dest();
      exp_t e;
`ifdef BUS_ARB_STATS_EN
      logic [15:0] dropBefore;
      logic [15:0] xferBefore;
      dropBefore = drop_cnt;
      xferBefore = xfer_cnt;
`endif
      loadWord(0, 16'h0711);
      loadWord(0, 16'h0011);
      addExpected(0, 16'h0711);
      addExpected(0, 16'h0011);
      applyStimulus();
      for (int k = 0; k < 2; k++) begin
         stepCycle();
         compared++;
         if (obsPop !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL bad_pop%0d: pop=%b, required 0001", k, obsPop);
         end
         stepCycle();
         e = sb.pop_front();
         compared++;
         if ((obsPush !== e.ePush) || (obsData !== e.eData) || (obsDrop !== e.eDrop) || (obsGid !== e.eGid)) begin
            mismatched++;
            $display("[TB] FAIL bad_drop%0d: push=%b data=%h drop=%b gid=%0d, required push=%b data=%h drop=%b gid=%0d",
                     k, obsPush, obsData, obsDrop, obsGid, e.ePush, e.eData, e.eDrop, e.eGid);
         end
      end
      stepCycle();
      compared++;
      if ((obsDrop !== 1'b0) || (obsBusy !== 1'b0)) begin
         mismatched++;
         $display("[TB] FAIL bad_pulse: drop=%b busy=%b, required drop=0 busy=0", obsDrop, obsBusy);
      end
`ifdef BUS_ARB_STATS_EN
      compared++;
      if (((drop_cnt - dropBefore) !== 16'd2) || ((xfer_cnt - xferBefore) !== 16'd0)) begin
         mismatched++;
         $display("[TB] FAIL bad_stats: drop delta=%0d xfer delta=%0d, required 2 and 0",
                  drop_cnt - dropBefore, xfer_cnt - xferBefore);
      end
`endif
   endtask

   task automatic test_reset_midop();
      exp_t e;
      bit   hit;
      hit = 1'b0;
      loadWord(3, 16'h0100);
      applyStimulus();
      for (int c = 0; (c < 10) && !hit; c++) begin
         stepCycle();
         if (obsPush != 4'b0) hit = 1'b1;
      end
      compared++;
      if (obsPush !== 4'b0010) begin
         mismatched++;
         $display("[TB] FAIL midop_deliver: push=%b, required 0010", obsPush);
      end
      reset = 1'b0;
      #1;
      compared++;
      if ((push !== 4'b0) || (pop !== 4'b0) || (bus_busy !== 1'b0) || (drop !== 1'b0)) begin
         mismatched++;
         $display("[TB] FAIL midop_async: push=%b pop=%b busy=%b drop=%b, required all zero", push, pop, bus_busy, drop);
      end
      obsPop = '0;
      @(negedge clk);
      loadWord(2, 16'h0100);
      loadWord(0, 16'h0200);
      addExpected(0, 16'h0200);
      addExpected(2, 16'h0100);
      applyStimulus();
      reset = 1'b1;
      for (int c = 0; (c < 20) && (sb.size() > 0); c++) begin
         stepCycle();
         if ((obsPush != 4'b0) || obsDrop) begin
            e = sb.pop_front();
            compared++;
            if ((obsPush !== e.ePush) || (obsData !== e.eData) || (obsDrop !== e.eDrop) || (obsGid !== e.eGid)) begin
               mismatched++;
               $display("[TB] FAIL midop_xfer: push=%b data=%h drop=%b gid=%0d, required push=%b data=%h drop=%b gid=%0d",
                        obsPush, obsData, obsDrop, obsGid, e.ePush, e.eData, e.eDrop, e.eGid);
            end
         end
      end
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL midop_timeout: %0d transfers outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         fifoHead[d]  = 0;
         fifoCount[d] = 0;
      end
      test_reset();
      test_fairness();
      test_single();
      test_broadcast();
      test_bad_dest();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
